// File: rtl/conv_stream_driver_if.sv
// Core-facing stream bundle: image/kernel samples out, results back.
// The driver owns the master side, the convolution core the slave side.
interface conv_stream_driver_if;
  logic [4:0]  IN_DATA_1;
  logic [4:0]  IN_DATA_2;
  logic [4:0]  IN_DATA_3;
  logic        IN_VALID;
  logic        KERNEL_VALID;
  logic [7:0]  KERNEL;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;

  modport master (
    output IN_DATA_1,
    output IN_DATA_2,
    output IN_DATA_3,
    output IN_VALID,
    output KERNEL_VALID,
    output KERNEL,
    input  OUT_DATA,
    input  OUT_VALID
  );

  modport slave (
    input  IN_DATA_1,
    input  IN_DATA_2,
    input  IN_DATA_3,
    input  IN_VALID,
    input  KERNEL_VALID,
    input  KERNEL,
    output OUT_DATA,
    output OUT_VALID
  );
endinterface

// File: rtl/conv_stream_driver.sv
// Streams image/kernel memories into a conv core and captures its results.
// Define CONV_DRV_CHECKSUM_EN to build the running result checksum.
module conv_stream_driver #(
  parameter int IMG_LEN = 100,
  parameter int KER_LEN = 24,
  parameter int OUT_LEN = IMG_LEN - 12,
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LD_EN,
  input  logic        LD_SEL,
  input  logic [6:0]  LD_ADDR,
  input  logic [14:0] LD_DATA,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  input  logic [6:0]  RD_ADDR,
  output logic [31:0] RD_DATA,
  output logic [31:0] CHECKSUM,
  conv_stream_driver_if.master core
);

  localparam int KW  = $clog2(IMG_LEN + 1);
  localparam int IAW = $clog2(IMG_LEN);
  localparam int KAW = $clog2(KER_LEN);
  localparam int RAW = $clog2(OUT_LEN);
  localparam int CW  = $clog2(OUT_LEN + 1);
  localparam int IW  = $clog2(TIMEOUT + 1);

  localparam logic [6:0]    IMG_LIM = 7'(IMG_LEN);
  localparam logic [6:0]    KER_LIM = 7'(KER_LEN);
  localparam logic [6:0]    RD_LIM  = 7'(OUT_LEN);
  localparam logic [KW-1:0] K_LAST  = KW'(IMG_LEN - 1);
  localparam logic [KW-1:0] K_KER   = KW'(KER_LEN);
  localparam logic [CW-1:0] C_FULL  = CW'(OUT_LEN);
  localparam logic [IW-1:0] I_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  state_t st;
  state_t st_nx;

  logic [14:0] img_mem [IMG_LEN];
  logic [7:0]  ker_mem [KER_LEN];
  logic [31:0] res_mem [OUT_LEN];

  logic [KW-1:0] k;
  logic [KW-1:0] k_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle;

  logic        in_valid;
  logic [14:0] in_word;
  logic        ker_valid;
  logic [7:0]  kernel;
  logic        done_q;
  logic        err_q;

  logic accept;
  logic run_st;
  logic strm_nx;
  logic ker_hit;
  logic cap;
  logic ovf;
  logic to_hit;

  assign accept  = (st == IDLE) && START;
  assign run_st  = (st == STREAM) || (st == DRAIN);
  assign cap     = run_st && core.OUT_VALID && (cnt != C_FULL);
  assign ovf     = run_st && core.OUT_VALID && (cnt == C_FULL);
  assign to_hit  = (st == DRAIN) && !cap && (idle == I_LAST);
  assign k_nx    = (st == STREAM) ? k + 1'b1 : '0;
  assign strm_nx = (st_nx == STREAM);
  assign ker_hit = (k_nx < K_KER);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (START) st_nx = STREAM;
      end
      STREAM: begin
        if (k == K_LAST) st_nx = DRAIN;
      end
      DRAIN: begin
        if (cnt == C_FULL || to_hit) st_nx = FIN;
      end
      FIN: begin
        st_nx = IDLE;
      end
    endcase
  end

  // Host loads only while idle; out-of-range addresses are dropped.
  always_ff @(posedge CLK) begin
    if (!RESET && st == IDLE && LD_EN) begin
      if (!LD_SEL && LD_ADDR < IMG_LIM)
        img_mem[LD_ADDR[IAW-1:0]] <= LD_DATA;
      if (LD_SEL && LD_ADDR < KER_LIM)
        ker_mem[LD_ADDR[KAW-1:0]] <= LD_DATA[7:0];
    end
  end

  // Core-facing outputs are registered from the next state and index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k         <= '0;
      in_valid  <= 1'b0;
      in_word   <= '0;
      ker_valid <= 1'b0;
      kernel    <= '0;
    end else begin
      k         <= strm_nx ? k_nx : '0;
      in_valid  <= strm_nx;
      in_word   <= strm_nx ? img_mem[k_nx[IAW-1:0]] : '0;
      ker_valid <= strm_nx && ker_hit;
      kernel    <= (strm_nx && ker_hit) ?
                   ker_mem[k_nx[KAW-1:0]] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && cap)
      res_mem[cnt[RAW-1:0]] <= core.OUT_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      idle   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (cap) cnt <= cnt + 1'b1;
      if (ovf || to_hit) err_q <= 1'b1;
      if (st == FIN) done_q <= 1'b1;
      // Idle run length only matters while draining.
      idle <= (st == DRAIN && !cap) ? idle + 1'b1 : '0;
    end
  end

`ifdef CONV_DRV_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (cap) begin
      csum <= csum + core.OUT_DATA;
    end
  end

  assign CHECKSUM = csum;
`else
  assign CHECKSUM = '0;
`endif

  assign RD_DATA = (RD_ADDR < RD_LIM) ?
                   res_mem[RD_ADDR[RAW-1:0]] : '0;

  assign BUSY = run_st;
  assign DONE = done_q;
  assign ERR  = err_q;

  assign core.IN_VALID     = in_valid;
  assign core.IN_DATA_1    = in_word[4:0];
  assign core.IN_DATA_2    = in_word[9:5];
  assign core.IN_DATA_3    = in_word[14:10];
  assign core.KERNEL_VALID = ker_valid;
  assign core.KERNEL       = kernel;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Randomized bench for conv_stream_driver against a run-level model.
// Checksum expectation follows CONV_DRV_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_conv_stream_driver;

  localparam int IMG_LEN = 100;
  localparam int KER_LEN = 24;
  localparam int OUT_LEN = 88;
  localparam int TIMEOUT = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LD_EN;
  logic        LD_SEL;
  logic [6:0]  LD_ADDR;
  logic [14:0] LD_DATA;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [6:0]  RD_ADDR;
  logic [31:0] RD_DATA;
  logic [31:0] CHECKSUM;

  conv_stream_driver_if core();

  conv_stream_driver dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .LD_EN    (LD_EN),
    .LD_SEL   (LD_SEL),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .START    (START),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (RD_DATA),
    .CHECKSUM (CHECKSUM),
    .core     (core)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [14:0] m_img [IMG_LEN];
  logic [7:0]  m_ker [KER_LEN];
  logic [31:0] m_res [OUT_LEN];
  bit          m_wr  [OUT_LEN];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input bit sel, input int addr,
                      input logic [14:0] d);
    LD_EN   = 1'b1;
    LD_SEL  = sel;
    LD_ADDR = 7'(addr);
    LD_DATA = d;
    step();
    LD_EN = 1'b0;
    if (!sel && addr < IMG_LEN) m_img[addr] = d;
    if (sel && addr < KER_LEN) m_ker[addr] = d[7:0];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    chk({tag, "_ivalid"}, 32'(core.IN_VALID), 32'd0);
    chk({tag, "_kvalid"}, 32'(core.KERNEL_VALID), 32'd0);
    chk({tag, "_idata"},
        32'({core.IN_DATA_3, core.IN_DATA_2, core.IN_DATA_1}), 32'd0);
    chk({tag, "_kernel"}, 32'(core.KERNEL), 32'd0);
    chk({tag, "_csum"}, CHECKSUM, 32'd0);
  endtask

  // Core model: n results, first at cycle lat after START, then
  // 0..gap idle cycles between results. Cycle 0 carries START.
  task automatic run(input int n, input int lat, input int gap,
                     input bit dir, input bit poke);
    int pc [128];
    logic [31:0] pd [128];
    int c, f, j, cl;
    bit e_err;
    logic [31:0] sum, e_in, e_k;
    c = lat;
    for (int i = 0; i < n; i++) begin
      pc[i] = c;
      pd[i] = dir ? 32'(i * 3) : $urandom;
      c += 1 + $urandom_range(gap, 0);
    end
    if (n >= OUT_LEN) begin
      cl = pc[OUT_LEN-1] + 1;
      f = ((cl > IMG_LEN + 1) ? cl : IMG_LEN + 1) + 1;
      e_err = (n > OUT_LEN) && (pc[OUT_LEN] <= f - 1);
    end else begin
      cl = (n > 0) ? pc[n-1] + 1 : 0;
      f = ((cl > IMG_LEN + 1) ? cl : IMG_LEN + 1) + TIMEOUT;
      e_err = 1'b1;
    end
    sum = '0;
    for (int i = 0; i < n && i < OUT_LEN; i++) begin
      m_res[i] = pd[i];
      m_wr[i]  = 1'b1;
      sum += pd[i];
    end
    START = 1'b1;
    step();
    j = 0;
    for (int r = 1; r <= f + 1; r++) begin
      START = 1'b0;
      LD_EN = 1'b0;
      core.OUT_VALID = 1'b0;
      core.OUT_DATA  = '0;
      if (j < n && pc[j] == r) begin
        core.OUT_VALID = 1'b1;
        core.OUT_DATA  = pd[j];
        j++;
      end
      e_in = '0;
      e_k  = '0;
      if (r <= IMG_LEN) e_in = 32'(m_img[r-1]);
      if (r <= KER_LEN) e_k = 32'(m_ker[r-1]);
      if (r == 1) chk("err_clr", 32'(ERR), 32'd0);
      chk("in_valid", 32'(core.IN_VALID), 32'(r <= IMG_LEN));
      chk("in_data",
          32'({core.IN_DATA_3, core.IN_DATA_2, core.IN_DATA_1}), e_in);
      chk("ker_valid", 32'(core.KERNEL_VALID), 32'(r <= KER_LEN));
      chk("kernel", 32'(core.KERNEL), e_k);
      chk("busy", 32'(BUSY), 32'(r < f));
      chk("done", 32'(DONE), 32'(r > f));
      if (poke && (r == 30 || r == IMG_LEN + 1 || r == f))
        START = 1'b1;
      if (poke && r == 30) begin
        LD_EN   = 1'b1;
        LD_SEL  = 1'($urandom);
        LD_ADDR = 7'(r + 20);
        LD_DATA = 15'($urandom);
      end
      step();
    end
    START = 1'b0;
    LD_EN = 1'b0;
    core.OUT_VALID = 1'b0;
    core.OUT_DATA  = '0;
    chk("err", 32'(ERR), 32'(e_err));
    chk("done_hold", 32'(DONE), 32'd1);
`ifdef CONV_DRV_CHECKSUM_EN
    chk("checksum", CHECKSUM, sum);
`else
    chk("checksum", CHECKSUM, 32'd0);
`endif
    for (int i = 0; i < OUT_LEN; i++) begin
      if (m_wr[i]) begin
        RD_ADDR = 7'(i);
        #1;
        chk("rd_data", RD_DATA, m_res[i]);
      end
    end
    step();
  endtask

  task automatic reset_mid();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int r = 1; r < 41; r++) step();
    chk("k40_data",
        32'({core.IN_DATA_3, core.IN_DATA_2, core.IN_DATA_1}),
        32'(m_img[40]));
    chk("k40_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk_zero("mid_rst");
    step();
  endtask

  int n;

  initial begin
    RESET   = 1'b1;
    LD_EN   = 1'b0;
    LD_SEL  = 1'b0;
    LD_ADDR = '0;
    LD_DATA = '0;
    START   = 1'b0;
    RD_ADDR = '0;
    core.OUT_VALID = 1'b0;
    core.OUT_DATA  = '0;
    for (int i = 0; i < OUT_LEN; i++) m_wr[i] = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    RESET = 1'b0;
    step();

    for (int k = 0; k < IMG_LEN; k++)
      load(1'b0, k, {5'(k % 32), 5'((k + 1) % 32), 5'((k + 2) % 32)});
    for (int k = 0; k < KER_LEN; k++)
      load(1'b1, k, {7'($urandom), 8'(k - 12)});
    load(1'b0, 100, 15'h7fff);
    load(1'b1, 24, 15'h00ff);

    run(88, 35, 0, 1'b1, 1'b0);
    run(50, 60, 0, 1'b0, 1'b0);
    run(89, 35, 0, 1'b0, 1'b0);
    run(88, $urandom_range(40, 1), 2, 1'b0, 1'b1);
    reset_mid();
    run(88, 35, 1, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      repeat (10)
        load(1'b0, $urandom_range(IMG_LEN - 1, 0), 15'($urandom));
      repeat (4)
        load(1'b1, $urandom_range(KER_LEN - 1, 0), 15'($urandom));
      load(1'b0, $urandom_range(127, IMG_LEN), 15'($urandom));
      load(1'b1, $urandom_range(127, KER_LEN), 15'($urandom));
      case ($urandom_range(3, 0))
        0: n = 88;
        1: n = 89 + $urandom_range(3, 0);
        default: n = $urandom_range(100, 0);
      endcase
      run(n, $urandom_range(40, 1), $urandom_range(2, 0),
          1'b0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
